rv_pipe_fifo: RTL and testbench

- Parametrised ready/valid buffer stage; successor to the single-entry pipeline register.
- Generalised to DEPTH entries. Exposes in_ready, occupancy count and an almost-full flag.
- Adds a synchronous flush and a selectable ready mode: pass-through ready, or fully registered backpressure.
- Inserted between streaming datapath stages to decouple producer and consumer timing.

---
 rtl/rv_pipe_fifo.sv | 128 ++++++++++++
 tb/tb_rv_pipe_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_pipe_fifo.sv
// ---------------------------------------------------------------------------
// rv_pipe_fifo
//   Parametrised ready/valid buffer stage. It decouples a producer from a
//   consumer with a DEPTH-entry circular buffer. The minimum latency is one
//   cycle, and there is no same-cycle bypass when the buffer is empty.
//
// Parameters
//   DATA_W          payload width in bits
//   DEPTH           number of storage entries (>= 1, any value)
//   PASSTHRU_READY  1: in_ready = !flush && (!full || out_ready)
//                   0: in_ready = !flush && !full (no comb path from out_ready)
//   AF_THRESH       almost_full asserts when count >= AF_THRESH (1..DEPTH)
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset; clears pointers, count, storage
//   flush        synchronous discard of all stored entries
//   in_valid     producer has data
//   in_data      producer payload
//   in_ready     block accepts in_data this cycle
//   out_valid    head entry is valid
//   out_data     head-of-queue payload, read directly from storage
//   out_ready    consumer accepts out_data this cycle
//   count        current occupancy
//   almost_full  count >= AF_THRESH
// ---------------------------------------------------------------------------
module rv_pipe_fifo #(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 4,
    parameter int PASSTHRU_READY = 1,
    parameter int AF_THRESH      = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // DEPTH need not be a power of two, so wrap explicitly rather than
    // relying on pointer overflow.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // Flush forces both handshakes low, so flush always takes priority
    // over any transfer in the same cycle.
    generate
        if (PASSTHRU_READY != 0) begin : g_ready_pass
            assign in_ready = !flush && (!w_full || out_ready);
        end else begin : g_ready_reg
            assign in_ready = !flush && !w_full;
        end
    endgenerate

    assign out_valid   = !w_empty && !flush;
    assign out_data    = r_mem[r_rd_ptr];
    assign count       = r_count;
    assign almost_full = (r_count >= AF_CNT);

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // Pointer and occupancy state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            // A simultaneous push and pop leaves the count unchanged,
            // including at full when the pass-through ready mode is used.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is cleared on reset so out_data reads 0 until the first write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_rv_pipe_fifo.sv
module tb_rv_pipe_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, af_a;
    logic [7:0] out_data_a;
    logic [2:0] count_a;
    logic       in_ready_b, out_valid_b, af_b;
    logic [7:0] out_data_b;
    logic [2:0] count_b;

    rv_pipe_fifo #(.DATA_W(8), .DEPTH(4), .PASSTHRU_READY(1), .AF_THRESH(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
        .out_valid(out_valid_a), .out_data(out_data_a), .out_ready(out_ready),
        .count(count_a), .almost_full(af_a)
    );

    rv_pipe_fifo #(.DATA_W(8), .DEPTH(4), .PASSTHRU_READY(0), .AF_THRESH(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
        .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(out_ready),
        .count(count_b), .almost_full(af_b)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] sb_a[$];
    logic [7:0] sb_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: observes each handshake at the falling edge (inputs and
    // outputs are stable there), compares the current state against the
    // queue contents, then applies the transfers that the next rising edge
    // will perform.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_a.delete();
            sb_b.delete();
        end else begin
            check("count_a", 32'(count_a), 32'(sb_a.size()));
            check("af_a", 32'(af_a), 32'(sb_a.size() >= 3));
            check("out_valid_a", 32'(out_valid_a), 32'(sb_a.size() != 0 && !flush));
            check("in_ready_a", 32'(in_ready_a), 32'(!flush && (sb_a.size() < 4 || out_ready)));
            check("count_b", 32'(count_b), 32'(sb_b.size()));
            check("af_b", 32'(af_b), 32'(sb_b.size() >= 3));
            check("out_valid_b", 32'(out_valid_b), 32'(sb_b.size() != 0 && !flush));
            check("in_ready_b", 32'(in_ready_b), 32'(!flush && sb_b.size() < 4));
            if (out_valid_a && out_ready) begin
                if (sb_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_a: got pop expected none (queue empty) at %0t", $time);
                end else begin
                    check("out_data_a", 32'(out_data_a), 32'(sb_a.pop_front()));
                end
            end
            if (out_valid_b && out_ready) begin
                if (sb_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_b: got pop expected none (queue empty) at %0t", $time);
                end else begin
                    check("out_data_b", 32'(out_data_b), 32'(sb_b.pop_front()));
                end
            end
            if (in_valid && in_ready_a) sb_a.push_back(in_data);
            if (in_valid && in_ready_b) sb_b.push_back(in_data);
            if (flush) begin
                sb_a.delete();
                sb_b.delete();
            end
        end
    end

    typedef struct {
        logic       fl;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       e_ir_a;
        logic       e_ir_b;
        logic [2:0] e_cnt;
        logic       e_af;
        logic [7:0] e_head;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [7:0] id, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
    endtask

    task automatic cyc(input logic fl, input logic iv, input logic [7:0] id, input logic ordy);
        drive(fl, iv, id, ordy);
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count_a"}, 32'(count_a), 32'd0);
        check({tag, "_ovld_a"}, 32'(out_valid_a), 32'd0);
        check({tag, "_odata_a"}, 32'(out_data_a), 32'd0);
        check({tag, "_af_a"}, 32'(af_a), 32'd0);
        check({tag, "_irdy_a"}, 32'(in_ready_a), 32'd1);
        check({tag, "_count_b"}, 32'(count_b), 32'd0);
        check({tag, "_ovld_b"}, 32'(out_valid_b), 32'd0);
        check({tag, "_odata_b"}, 32'(out_data_b), 32'd0);
        check({tag, "_irdy_b"}, 32'(in_ready_b), 32'd1);
    endtask

    initial begin
        // Fill/drain: in_ready drops at count 4 in both modes, almost_full at 3.
        vecs.push_back('{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 8'h11});
        vecs.push_back('{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 8'h11});
        vecs.push_back('{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 8'h11});
        vecs.push_back('{1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 3'd4, 1'b1, 8'h11});
        vecs.push_back('{1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 8'h11});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 8'h22});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 8'h33});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 8'h44});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 8'h00});
        // Streaming: steady count 1, pointers wrap twice.
        for (int k = 0; k < 10; k++) begin
            vecs.push_back('{1'b0, 1'b1, 8'(k), 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 8'(k)});
        end
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 8'h00});

        rst_n = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("init");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ordy);
            @(negedge clk);
            check($sformatf("v%0d_irdy_a", i), 32'(in_ready_a), 32'(vecs[i].e_ir_a));
            check($sformatf("v%0d_irdy_b", i), 32'(in_ready_b), 32'(vecs[i].e_ir_b));
            step();
            check($sformatf("v%0d_cnt_a", i), 32'(count_a), 32'(vecs[i].e_cnt));
            check($sformatf("v%0d_cnt_b", i), 32'(count_b), 32'(vecs[i].e_cnt));
            check($sformatf("v%0d_af_a", i), 32'(af_a), 32'(vecs[i].e_af));
            if (vecs[i].e_cnt != 3'd0) begin
                check($sformatf("v%0d_head_a", i), 32'(out_data_a), 32'(vecs[i].e_head));
                check($sformatf("v%0d_head_b", i), 32'(out_data_b), 32'(vecs[i].e_head));
            end
        end

        // Backpressure hold at count 2.
        cyc(1'b0, 1'b1, 8'hA1, 1'b0);
        cyc(1'b0, 1'b1, 8'hB2, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b0);
            check("hold_ovld_a", 32'(out_valid_a), 32'd1);
            check("hold_data_a", 32'(out_data_a), 32'hA1);
            check("hold_cnt_a", 32'(count_a), 32'd2);
            check("hold_data_b", 32'(out_data_b), 32'hA1);
        end

        // Flush at count 3 with both handshakes requested.
        cyc(1'b0, 1'b1, 8'hC3, 1'b0);
        check("pre_flush_cnt_a", 32'(count_a), 32'd3);
        drive(1'b1, 1'b1, 8'hEE, 1'b1);
        @(negedge clk);
        check("flush_irdy_a", 32'(in_ready_a), 32'd0);
        check("flush_irdy_b", 32'(in_ready_b), 32'd0);
        check("flush_ovld_a", 32'(out_valid_a), 32'd0);
        check("flush_ovld_b", 32'(out_valid_b), 32'd0);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        check("post_flush_cnt_a", 32'(count_a), 32'd0);
        check("post_flush_cnt_b", 32'(count_b), 32'd0);
        cyc(1'b0, 1'b1, 8'hAA, 1'b0);
        check("flush_head_a", 32'(out_data_a), 32'hAA);
        check("flush_head_b", 32'(out_data_b), 32'hAA);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // Full concurrent push/pop: mode 1 swaps, mode 0 only pops.
        cyc(1'b0, 1'b1, 8'h11, 1'b0);
        cyc(1'b0, 1'b1, 8'h22, 1'b0);
        cyc(1'b0, 1'b1, 8'h33, 1'b0);
        cyc(1'b0, 1'b1, 8'h44, 1'b0);
        drive(1'b0, 1'b1, 8'h55, 1'b1);
        @(negedge clk);
        check("full_irdy_a", 32'(in_ready_a), 32'd1);
        check("full_irdy_b", 32'(in_ready_b), 32'd0);
        step();
        check("full_cnt_a", 32'(count_a), 32'd4);
        check("full_cnt_b", 32'(count_b), 32'd3);
        check("full_head_a", 32'(out_data_a), 32'h22);
        check("full_head_b", 32'(out_data_b), 32'h22);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 8'h00, 1'b1);
        check("drained_cnt_a", 32'(count_a), 32'd0);
        check("drained_cnt_b", 32'(count_b), 32'd0);

        // Asynchronous reset mid-transfer at count 2.
        cyc(1'b0, 1'b1, 8'h01, 1'b0);
        cyc(1'b0, 1'b1, 8'h02, 1'b0);
        drive(1'b0, 1'b1, 8'h77, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("arst");
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        check("rel_odata_a", 32'(out_data_a), 32'd0);
        check("rel_cnt_a", 32'(count_a), 32'd0);
        cyc(1'b0, 1'b1, 8'h5A, 1'b0);
        check("rel_head_a", 32'(out_data_a), 32'h5A);
        check("rel_head_b", 32'(out_data_b), 32'h5A);
        check("rel_ovld_a", 32'(out_valid_a), 32'd1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        check("end_cnt_a", 32'(count_a), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
